flag_file: RTL and testbench

- Flag storage stage directly downstream of the C/Z flag-load muxes in the CPU datapath.
- Holds the architectural C, Z and I flags and their shadow copies, which are saved on interrupt entry and restored on RETIE.
- Also owns the interrupt request path: synchronizes the external INTR pin, latches a pending request, and presents a gated interrupt to the control unit FSM.
- All flag outputs feed the branch-condition logic and the ALU carry-in.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/intr_sync_edge.sv | 44 ++++
 rtl/flag_file.sv | 90 +++++++++
 tb/tb_flag_file.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: flag load sources and
// interrupt synchronizer defaults.
package cpu_pkg;

    localparam logic FLG_SRC_ALU  = 1'b0;
    localparam logic FLG_SRC_SHAD = 1'b1;

    localparam int SYNC_STAGES_DEF = 2;

    typedef struct packed {
        logic c;
        logic z;
        logic i;
    } flags_t;

    // Keeps the synchronizer depth inside its usable range.
    function automatic int clamp_sync(input int n);
        if (n < 2) return 2;
        if (n > 4) return 4;
        return n;
    endfunction

endpackage

// File: rtl/intr_sync_edge.sv
// INTR synchronizer, rising-edge detector and pending latch
// cleared by the control unit's interrupt acknowledge.
module intr_sync_edge
    import cpu_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic intr,
    input  logic ack,
    output logic pending,
    output logic edge_pulse
);

    localparam int N = clamp_sync(SYNC_STAGES);

    logic [N-1:0] sync_q, sync_d;
    logic         hist_q, hist_d;
    logic         pend_q, pend_d;

    always_comb begin
        sync_d     = {sync_q[N-2:0], intr};
        hist_d     = sync_q[N-1];
        edge_pulse = sync_q[N-1] & ~hist_q;
        // A fresh edge wins over ack so a back-to-back request is kept.
        pend_d     = edge_pulse | (pend_q & ~ack);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            hist_q <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
            pend_q <= pend_d;
        end
    end

    assign pending = pend_q;

endmodule

// File: rtl/flag_file.sv
// Architectural C/Z/I flags with shadow copies for interrupt
// entry/RETIE, plus the gated interrupt request to control.
module flag_file
    import cpu_pkg::*;
#(
    parameter int   SYNC_STAGES = SYNC_STAGES_DEF,
    parameter logic I_RESET_VAL = 1'b0
) (
    input  logic CLK,
    input  logic RST,
    input  logic C_IN,
    input  logic Z_IN,
    input  logic FLG_C_LD,
    input  logic FLG_Z_LD,
    input  logic FLG_C_SET,
    input  logic FLG_C_CLR,
    input  logic FLG_LD_SEL,
    input  logic FLG_SHAD_LD,
    input  logic I_SET,
    input  logic I_CLR,
    input  logic INTR,
    input  logic INT_ACK,
    output logic C_FLAG,
    output logic Z_FLAG,
    output logic I_FLAG,
    output logic SHAD_C,
    output logic SHAD_Z,
    output logic INT_OUT
);

    flags_t flg_q, flg_d;
    flags_t shad_q, shad_d;
    logic   src_c, src_z;
    logic   pending;
    logic   edge_pulse;
    logic   unused_sig;

    intr_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_intr (
        .clk       (CLK),
        .rst       (RST),
        .intr      (INTR),
        .ack       (INT_ACK),
        .pending   (pending),
        .edge_pulse(edge_pulse)
    );

    always_comb begin
        src_c = (FLG_LD_SEL == FLG_SRC_SHAD) ? shad_q.c : C_IN;
        src_z = (FLG_LD_SEL == FLG_SRC_SHAD) ? shad_q.z : Z_IN;

        flg_d  = flg_q;
        shad_d = shad_q;

        if (FLG_C_CLR)      flg_d.c = 1'b0;
        else if (FLG_C_SET) flg_d.c = 1'b1;
        else if (FLG_C_LD)  flg_d.c = src_c;

        if (FLG_Z_LD) flg_d.z = src_z;

        if (INT_ACK)    flg_d.i = 1'b0;
        else if (I_CLR) flg_d.i = 1'b0;
        else if (I_SET) flg_d.i = 1'b1;

        // Shadow takes pre-edge flags, so restore+save is a swap.
        if (FLG_SHAD_LD) shad_d = flg_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            flg_q  <= '{c: 1'b0, z: 1'b0, i: I_RESET_VAL};
            shad_q <= '0;
        end else begin
            flg_q  <= flg_d;
            shad_q <= shad_d;
        end
    end

    assign C_FLAG  = flg_q.c;
    assign Z_FLAG  = flg_q.z;
    assign I_FLAG  = flg_q.i;
    assign SHAD_C  = shad_q.c;
    assign SHAD_Z  = shad_q.z;
    assign INT_OUT = pending & flg_q.i;

    // Shadow I and the raw edge pulse have no consumer here yet.
    assign unused_sig = shad_q.i ^ edge_pulse;

endmodule

// File: tb/tb_flag_file.sv
// Directed scoreboard bench for flag_file (SYNC_STAGES=2,
// I_RESET_VAL=0); outputs sampled 1 time unit after each edge.
module tb_flag_file;

    logic CLK = 1'b0;
    logic RST;
    logic C_IN, Z_IN;
    logic FLG_C_LD, FLG_Z_LD, FLG_C_SET, FLG_C_CLR;
    logic FLG_LD_SEL, FLG_SHAD_LD;
    logic I_SET, I_CLR, INTR, INT_ACK;
    logic C_FLAG, Z_FLAG, I_FLAG, SHAD_C, SHAD_Z, INT_OUT;

    int tests = 0;
    int fails = 0;
    logic [5:0] sb[$];

    always #5 CLK = ~CLK;

    flag_file #(
        .SYNC_STAGES(2),
        .I_RESET_VAL(1'b0)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .C_IN       (C_IN),
        .Z_IN       (Z_IN),
        .FLG_C_LD   (FLG_C_LD),
        .FLG_Z_LD   (FLG_Z_LD),
        .FLG_C_SET  (FLG_C_SET),
        .FLG_C_CLR  (FLG_C_CLR),
        .FLG_LD_SEL (FLG_LD_SEL),
        .FLG_SHAD_LD(FLG_SHAD_LD),
        .I_SET      (I_SET),
        .I_CLR      (I_CLR),
        .INTR       (INTR),
        .INT_ACK    (INT_ACK),
        .C_FLAG     (C_FLAG),
        .Z_FLAG     (Z_FLAG),
        .I_FLAG     (I_FLAG),
        .SHAD_C     (SHAD_C),
        .SHAD_Z     (SHAD_Z),
        .INT_OUT    (INT_OUT)
    );

    // Expected vector layout: {C, Z, I, SHAD_C, SHAD_Z, INT_OUT}
    function automatic logic [5:0] mk(
        input logic c, input logic z, input logic i,
        input logic sc, input logic sz, input logic io
    );
        return {c, z, i, sc, sz, io};
    endfunction

    task automatic check(input string tag);
        logic [5:0] e;
        logic [5:0] obs;
        tests++;
        obs = {C_FLAG, Z_FLAG, I_FLAG, SHAD_C, SHAD_Z, INT_OUT};
        if (sb.size() == 0) begin
            fails++;
            $error("FAIL %s scoreboard empty, observed=%b", tag, obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e) else begin
                fails++;
                $error("FAIL %s observed=%b expected=%b", tag, obs, e);
            end
        end
    endtask

    task automatic step(input string tag, input logic [5:0] e);
        sb.push_back(e);
        @(posedge CLK);
        #1;
        check(tag);
    endtask

    task automatic idle();
        FLG_C_LD    = 1'b0;
        FLG_Z_LD    = 1'b0;
        FLG_C_SET   = 1'b0;
        FLG_C_CLR   = 1'b0;
        FLG_LD_SEL  = 1'b0;
        FLG_SHAD_LD = 1'b0;
        I_SET       = 1'b0;
        I_CLR       = 1'b0;
        INT_ACK     = 1'b0;
    endtask

    initial begin
        idle();
        C_IN = 1'b0;
        Z_IN = 1'b0;
        INTR = 1'b0;
        RST  = 1'b1;
        #2;
        sb.push_back(mk(0, 0, 0, 0, 0, 0));
        check("reset_state");
        @(posedge CLK);
        #1;
        RST = 1'b0;

        C_IN = 1'b1; Z_IN = 1'b0;
        FLG_C_LD = 1'b1; FLG_Z_LD = 1'b1;
        step("alu_load", mk(1, 0, 0, 0, 0, 0));

        idle(); FLG_C_SET = 1'b1; FLG_C_CLR = 1'b1;
        step("set_clr_both", mk(0, 0, 0, 0, 0, 0));

        idle(); FLG_C_SET = 1'b1;
        step("sec", mk(1, 0, 0, 0, 0, 0));

        idle(); C_IN = 1'b1; Z_IN = 1'b1;
        FLG_C_LD = 1'b1; FLG_Z_LD = 1'b1;
        step("load_11", mk(1, 1, 0, 0, 0, 0));

        idle(); FLG_SHAD_LD = 1'b1;
        step("shad_save", mk(1, 1, 0, 1, 1, 0));

        idle(); C_IN = 1'b0; Z_IN = 1'b0;
        FLG_C_LD = 1'b1; FLG_Z_LD = 1'b1;
        step("load_00", mk(0, 0, 0, 1, 1, 0));

        idle(); FLG_LD_SEL = 1'b1;
        FLG_C_LD = 1'b1; FLG_Z_LD = 1'b1;
        step("shad_restore", mk(1, 1, 0, 1, 1, 0));

        idle(); C_IN = 1'b0; Z_IN = 1'b0;
        FLG_SHAD_LD = 1'b1; FLG_C_LD = 1'b1;
        step("shad_with_ld", mk(0, 1, 0, 1, 1, 0));

        idle(); FLG_SHAD_LD = 1'b1; FLG_LD_SEL = 1'b1;
        FLG_C_LD = 1'b1; FLG_Z_LD = 1'b1;
        step("shad_swap", mk(1, 1, 0, 0, 1, 0));

        idle(); I_SET = 1'b1;
        step("sei", mk(1, 1, 1, 0, 1, 0));

        idle(); INTR = 1'b1;
        step("intr_edge1", mk(1, 1, 1, 0, 1, 0));
        step("intr_edge2", mk(1, 1, 1, 0, 1, 0));
        step("intr_edge3", mk(1, 1, 1, 0, 1, 1));

        INT_ACK = 1'b1;
        step("int_ack", mk(1, 1, 0, 0, 1, 0));

        idle(); I_SET = 1'b1;
        step("sei_after_ack", mk(1, 1, 1, 0, 1, 0));
        idle();
        for (int k = 0; k < 5; k++)
            step("intr_held_high", mk(1, 1, 1, 0, 1, 0));

        I_CLR = 1'b1;
        step("cli", mk(1, 1, 0, 0, 1, 0));
        idle(); INTR = 1'b0;
        for (int k = 0; k < 3; k++)
            step("intr_low", mk(1, 1, 0, 0, 1, 0));
        INTR = 1'b1;
        for (int k = 0; k < 4; k++)
            step("masked_pending", mk(1, 1, 0, 0, 1, 0));

        I_SET = 1'b1;
        step("unmask_pending", mk(1, 1, 1, 0, 1, 1));

        idle(); INT_ACK = 1'b1;
        step("ack_clears", mk(1, 1, 0, 0, 1, 0));
        idle(); I_SET = 1'b1;
        step("no_pending", mk(1, 1, 1, 0, 1, 0));

        idle(); INTR = 1'b0;
        for (int k = 0; k < 3; k++)
            step("rearm_low", mk(1, 1, 1, 0, 1, 0));
        INTR = 1'b1;
        step("rearm_edge1", mk(1, 1, 1, 0, 1, 0));
        step("rearm_edge2", mk(1, 1, 1, 0, 1, 0));
        INT_ACK = 1'b1;
        step("edge_with_ack", mk(1, 1, 0, 0, 1, 0));
        idle(); I_SET = 1'b1;
        step("edge_kept", mk(1, 1, 1, 0, 1, 1));

        idle();
        #2;
        RST = 1'b1;
        #1;
        sb.push_back(mk(0, 0, 0, 0, 0, 0));
        check("async_reset_mid");
        @(posedge CLK);
        #1;
        RST = 1'b0;
        step("post_reset", mk(0, 0, 0, 0, 0, 0));
        I_SET = 1'b1;
        step("post_reset_sei", mk(0, 0, 1, 0, 0, 0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
